// File: rtl/mem_port_sequencer.sv
// Single-port SRAM owner: loader -> CPU -> diag halt/resume sequencing, plus write snoop
// into NUM_WIN mirror windows. Optional alias hit on window 0 with `define MEM_MIRROR_ALIAS_EN.

module mem_mirror_win #(
  parameter int ADDR_W = 16,
  parameter int MIR_AW = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_sel,
  input  logic [ADDR_W-1:0] cfg_start,
  input  logic [ADDR_W-1:0] cfg_end,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr,
  input  logic              alias_wr,
  output logic              hit,
  output logic [MIR_AW-1:0] off
);
  logic [ADDR_W-1:0] start_q, end_q;
  logic              en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q <= '0;
      end_q   <= '0;
    end else if (cfg_sel) begin
      start_q <= cfg_start;
      end_q   <= cfg_end;
    end
  end

  assign en  = start_q < end_q;
  assign hit = wr & en & (alias_wr | ((addr >= start_q) & (addr < end_q)));
  // Alias writes land on the last byte of the window, even if the address is also in range.
  assign off = alias_wr ? MIR_AW'(end_q - start_q - 1'b1) : MIR_AW'(addr - start_q);
endmodule

module mem_port_sequencer #(
  parameter int                ADDR_W      = 16,
  parameter int                DATA_W      = 8,
  parameter int                NUM_WIN     = 4,
  parameter int                MIR_AW      = 11,
  parameter int                HALT_SETTLE = 2,
  parameter logic [ADDR_W-1:0] ALIAS_ADDR  = 16'hE84C
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_done,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_cs,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  input  logic              cpu_cs,
  input  logic              cpu_we,
  input  logic              cpu_access_active,
  input  logic              halt_req,
  output logic              halt_ack,
  output logic              cpu_rdy,
  input  logic [ADDR_W-1:0] diag_addr,
  input  logic [DATA_W-1:0] diag_data,
  input  logic              diag_cs,
  input  logic              diag_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_cs,
  output logic              ram_we,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_idx,
  input  logic [ADDR_W-1:0] cfg_start,
  input  logic [ADDR_W-1:0] cfg_end,
  output logic              mir_we,
  output logic [MIR_AW-1:0] mir_addr,
  output logic [DATA_W-1:0] mir_data,
  output logic [3:0]        mir_idx,
  output logic [2:0]        state
);
  localparam logic [2:0] S_LOAD   = 3'd0;
  localparam logic [2:0] S_RUN    = 3'd1;
  localparam logic [2:0] S_DRAIN  = 3'd2;
  localparam logic [2:0] S_HALT   = 3'd3;
  localparam logic [2:0] S_RESUME = 3'd4;

`ifdef MEM_MIRROR_ALIAS_EN
  localparam bit ALIAS_EN = 1'b1;
`else
  localparam bit ALIAS_EN = 1'b0;
`endif

  logic [3:0] settle_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_LOAD;
      settle_q <= '0;
    end else begin
      case (state)
        S_LOAD: if (load_done) state <= S_RUN;
        S_RUN: if (halt_req) begin
          state    <= S_DRAIN;
          settle_q <= 4'(HALT_SETTLE);
        end
        S_DRAIN: begin
          // Dropping the request aborts the halt before diag ever sees the port.
          if (!halt_req)               state    <= S_RUN;
          else if (cpu_access_active)  settle_q <= 4'(HALT_SETTLE);
          else if (settle_q == 4'd0)   state    <= S_HALT;
          else                         settle_q <= settle_q - 4'd1;
        end
        S_HALT:   if (!halt_req) state <= S_RESUME;
        S_RESUME: state <= S_RUN;
        default:  state <= S_LOAD;
      endcase
    end
  end

  assign cpu_rdy  = (state == S_RUN);
  assign halt_ack = (state == S_HALT);

  always_comb begin
    ram_addr = '0;
    ram_din  = '0;
    ram_cs   = 1'b0;
    ram_we   = 1'b0;
    case (state)
      S_LOAD: begin
        ram_addr = ld_addr; ram_din = ld_data; ram_cs = ld_cs; ram_we = ld_we;
      end
      S_RUN, S_DRAIN: begin
        ram_addr = cpu_addr; ram_din = cpu_data; ram_cs = cpu_cs; ram_we = cpu_we;
      end
      S_HALT: begin
        ram_addr = diag_addr; ram_din = diag_data; ram_cs = diag_cs; ram_we = diag_we;
      end
      default: ;
    endcase
  end

  logic                           wr;
  logic                           alias_wr;
  logic [NUM_WIN-1:0]             win_hit;
  logic [NUM_WIN-1:0][MIR_AW-1:0] win_off;

  assign wr       = ram_cs & ram_we;
  assign alias_wr = ALIAS_EN && (ram_addr == ALIAS_ADDR);

  for (genvar i = 0; i < NUM_WIN; i++) begin : g_win
    mem_mirror_win #(.ADDR_W(ADDR_W), .MIR_AW(MIR_AW)) u_win (
      .clk       (clk),
      .rst       (rst),
      .cfg_sel   (cfg_we && (cfg_idx == 4'(i))),
      .cfg_start (cfg_start),
      .cfg_end   (cfg_end),
      .addr      (ram_addr),
      .wr        (wr),
      .alias_wr  ((i == 0) ? alias_wr : 1'b0),
      .hit       (win_hit[i]),
      .off       (win_off[i])
    );
  end

  logic [3:0]        sel_idx;
  logic [MIR_AW-1:0] sel_off;

  always_comb begin
    sel_idx = '0;
    sel_off = '0;
    for (int i = NUM_WIN - 1; i >= 0; i--) begin
      if (win_hit[i]) begin
        sel_idx = 4'(i);
        sel_off = win_off[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mir_we   <= 1'b0;
      mir_addr <= '0;
      mir_data <= '0;
      mir_idx  <= '0;
    end else begin
      mir_we <= |win_hit;
      if (|win_hit) begin
        mir_addr <= sel_off;
        mir_data <= ram_din;
        mir_idx  <= sel_idx;
      end
    end
  end
endmodule

// File: tb/tb_mem_port_sequencer.sv
// Directed bench for mem_port_sequencer: boot, halt/resume, abort, mirror windows, reset.
`timescale 1ns/1ps
module tb_mem_port_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        load_done;
  logic [15:0] ld_addr, cpu_addr, diag_addr, ram_addr, cfg_start, cfg_end;
  logic [7:0]  ld_data, cpu_data, diag_data, ram_din, mir_data;
  logic        ld_cs, ld_we, cpu_cs, cpu_we, cpu_access_active, halt_req, halt_ack, cpu_rdy;
  logic        diag_cs, diag_we, ram_cs, ram_we, cfg_we, mir_we;
  logic [3:0]  cfg_idx, mir_idx;
  logic [10:0] mir_addr;
  logic [2:0]  state;

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_port_sequencer dut (
    .clk(clk), .rst(rst), .load_done(load_done),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_cs(ld_cs), .ld_we(ld_we),
    .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_cs(cpu_cs), .cpu_we(cpu_we),
    .cpu_access_active(cpu_access_active), .halt_req(halt_req),
    .halt_ack(halt_ack), .cpu_rdy(cpu_rdy),
    .diag_addr(diag_addr), .diag_data(diag_data), .diag_cs(diag_cs), .diag_we(diag_we),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_cs(ram_cs), .ram_we(ram_we),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_start(cfg_start), .cfg_end(cfg_end),
    .mir_we(mir_we), .mir_addr(mir_addr), .mir_data(mir_data), .mir_idx(mir_idx),
    .state(state)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [3:0] idx, input logic [15:0] s, input logic [15:0] e);
    cfg_we = 1'b1; cfg_idx = idx; cfg_start = s; cfg_end = e;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
    cpu_addr = a; cpu_data = d; cpu_cs = 1'b1; cpu_we = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b1; load_done = 1'b0;
    ld_addr = 16'h1234; ld_data = 8'h5A; ld_cs = 1'b1; ld_we = 1'b1;
    cpu_addr = '0; cpu_data = '0; cpu_cs = 1'b0; cpu_we = 1'b0; cpu_access_active = 1'b0;
    halt_req = 1'b0; diag_addr = '0; diag_data = '0; diag_cs = 1'b0; diag_we = 1'b0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_start = '0; cfg_end = '0;
    #1;
    chk("rst_state", 32'(state), 0);
    chk("rst_cpu_rdy", 32'(cpu_rdy), 0);
    chk("rst_halt_ack", 32'(halt_ack), 0);
    chk("rst_mir_we", 32'(mir_we), 0);
    chk("load_ram_addr", 32'(ram_addr), 32'h1234);
    tick(2);
    rst = 1'b0;
    tick();
    chk("load_hold", 32'(state), 0);

    // boot: loader -> CPU
    load_done = 1'b1;
    tick();
    chk("run_state", 32'(state), 1);
    chk("run_cpu_rdy", 32'(cpu_rdy), 1);
    cpu_addr = 16'h4321; cpu_cs = 1'b1;
    #1;
    chk("run_ram_addr", 32'(ram_addr), 32'h4321);
    load_done = 1'b0;
    tick();
    chk("load_done_sticky", 32'(state), 1);

    // mirror windows
    cfg(4'd1, 16'h8000, 16'h8800);
    cfg(4'd0, 16'h8400, 16'h8500);
    cpu_wr(16'h8450, 8'hA5);
    chk("w0_mir_we", 32'(mir_we), 1);
    chk("w0_mir_idx", 32'(mir_idx), 0);
    chk("w0_mir_addr", 32'(mir_addr), 32'h050);
    chk("w0_mir_data", 32'(mir_data), 32'hA5);
    cpu_wr(16'h8800, 8'h11);
    chk("end_excl_mir_we", 32'(mir_we), 0);
    chk("nohit_hold_addr", 32'(mir_addr), 32'h050);
    cpu_wr(16'h8500, 8'h3C);
    chk("w1_mir_idx", 32'(mir_idx), 1);
    chk("w1_mir_addr", 32'(mir_addr), 32'h500);
    chk("w1_mir_data", 32'(mir_data), 32'h3C);
    cfg(4'd0, 16'h8000, 16'h8800);
    cpu_wr(16'hE84C, 8'h0E);
`ifdef MEM_MIRROR_ALIAS_EN
    chk("alias_mir_we", 32'(mir_we), 1);
    chk("alias_mir_idx", 32'(mir_idx), 0);
    chk("alias_mir_addr", 32'(mir_addr), 32'h7FF);
`else
    chk("alias_off_mir_we", 32'(mir_we), 0);
`endif
    cpu_we = 1'b0;

    // halt with bus busy for 5 clocks
    cpu_access_active = 1'b1; halt_req = 1'b1;
    tick();
    chk("drain_state", 32'(state), 2);
    chk("drain_cpu_rdy", 32'(cpu_rdy), 0);
    tick(4);
    chk("drain_busy", 32'(state), 2);
    cpu_access_active = 1'b0;
    tick(2);
    chk("settle_not_yet", 32'(halt_ack), 0);
    tick();
    chk("halt_ack_3clk", 32'(halt_ack), 1);
    chk("halt_state", 32'(state), 3);
    diag_addr = 16'h8010; diag_data = 8'h77; diag_cs = 1'b1; diag_we = 1'b1;
    #1;
    chk("diag_ram_addr", 32'(ram_addr), 32'h8010);
    tick();
    chk("diag_mir_we", 32'(mir_we), 1);
    chk("diag_mir_addr", 32'(mir_addr), 32'h010);
    diag_we = 1'b0;

    // resume
    halt_req = 1'b0;
    tick();
    chk("resume_state", 32'(state), 4);
    chk("resume_ram_cs", 32'(ram_cs), 0);
    chk("resume_ram_addr", 32'(ram_addr), 0);
    chk("resume_cpu_rdy", 32'(cpu_rdy), 0);
    tick();
    chk("resumed_state", 32'(state), 1);
    chk("resumed_cpu_rdy", 32'(cpu_rdy), 1);

    // halt aborted during drain
    halt_req = 1'b1;
    tick();
    chk("abort_drain", 32'(state), 2);
    halt_req = 1'b0;
    tick();
    chk("abort_run", 32'(state), 1);
    chk("abort_halt_ack", 32'(halt_ack), 0);
    tick(4);
    chk("abort_stays_run", 32'(state), 1);

    // halt with idle bus, then reset while halted with a mirror write pending
    halt_req = 1'b1;
    tick(3);
    chk("idle_settle", 32'(state), 2);
    tick();
    chk("idle_halt_ack", 32'(halt_ack), 1);
    diag_we = 1'b1;
    tick();
    chk("pre_rst_mir_we", 32'(mir_we), 1);
    rst = 1'b1;
    #1;
    chk("arst_halt_ack", 32'(halt_ack), 0);
    chk("arst_cpu_rdy", 32'(cpu_rdy), 0);
    chk("arst_mir_we", 32'(mir_we), 0);
    chk("arst_state", 32'(state), 0);
    tick();
    rst = 1'b0; halt_req = 1'b0;
    ld_addr = 16'h8450; ld_data = 8'h99;
    tick();
    chk("table_cleared", 32'(mir_we), 0);
    chk("reload_needed", 32'(state), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
